calc_cmd_issuer: RTL

//  Upstream command stage for the 8-bit calc datapath. Buffers (operand, op) commands in a

---
 rtl/calc_cmd_issuer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_cmd_issuer
//  Description : Command front-end for the 8-bit calc datapath. Queues
//                (operand, op) commands, issues them one at a time over the
//                calc s/done handshake, and returns results on a valid/ready
//                port. A watchdog aborts commands stuck on a hung calc.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [7:0]                 cmd_in_i,
  input  logic [1:0]                 cmd_op_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [7:0]                 res_out_o,
  output logic                       res_ovf_o,
  output logic                       res_timeout_o,
  output logic                       calc_s_o,
  output logic [7:0]                 calc_in_o,
  output logic [1:0]                 calc_op_o,
  input  logic [7:0]                 calc_out_i,
  input  logic                       calc_ovf_i,
  input  logic                       calc_done_i,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] C_TMAX = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_ABORT     = 3'd4;

  // Command storage: {op, operand}
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          calc_s_q;
  logic [7:0]    calc_in_q;
  logic [1:0]    calc_op_q;
  logic          res_valid_q;
  logic [7:0]    res_out_q;
  logic          res_ovf_q;
  logic          res_timeout_q;

  logic          w_push;
  logic          w_pop;
  logic          w_can_issue;
  logic          w_capture;
  logic          w_abort;
  logic          w_busy;

  // Full means full: a same-cycle pop never frees a slot for the pusher.
  assign cmd_ready_o = (count_q < C_FULL);
  assign w_push      = cmd_valid_i & cmd_ready_o;
  // Issue only when calc is idle and the previous result has been taken.
  assign w_can_issue = (count_q != '0) & calc_done_i & ~res_valid_q;

  // Command FIFO pointers, occupancy and storage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= {cmd_op_i, cmd_in_i};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state and watchdog timer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and timer logic; the timer restarts on every phase change.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (w_can_issue) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!calc_done_i) begin
          state_d = S_WAIT_DONE;
          timer_d = '0;
        end else if (timer_q == C_TMAX) begin
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (calc_done_i) begin
          state_d = S_IDLE;
        end else if (timer_q == C_TMAX) begin
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Per-state control strobes for the FIFO and the result registers.
  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    w_busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        w_busy = 1'b0;
        w_pop  = w_can_issue;
      end
      S_WAIT_DONE: w_capture = calc_done_i;
      S_ABORT:     w_abort   = 1'b1;
      default:     w_busy    = 1'b1;
    endcase
  end

  // Calc drive registers and the held result; operands stay put until the next load.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      calc_s_q      <= 1'b0;
      calc_in_q     <= '0;
      calc_op_q     <= '0;
      res_valid_q   <= 1'b0;
      res_out_q     <= '0;
      res_ovf_q     <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      calc_s_q <= (state_q == S_ISSUE);
      if (w_pop) begin
        calc_in_q <= mem_q[rd_ptr_q][7:0];
        calc_op_q <= mem_q[rd_ptr_q][9:8];
      end
      if (w_capture) begin
        res_out_q     <= calc_out_i;
        res_ovf_q     <= calc_ovf_i;
        res_timeout_q <= 1'b0;
        res_valid_q   <= 1'b1;
      end else if (w_abort) begin
        res_out_q     <= '0;
        res_ovf_q     <= 1'b0;
        res_timeout_q <= 1'b1;
        res_valid_q   <= 1'b1;
      end else if (res_valid_q && res_ready_i) begin
        res_valid_q   <= 1'b0;
      end
    end
  end

  assign calc_s_o      = calc_s_q;
  assign calc_in_o     = calc_in_q;
  assign calc_op_o     = calc_op_q;
  assign res_valid_o   = res_valid_q;
  assign res_out_o     = res_out_q;
  assign res_ovf_o     = res_ovf_q;
  assign res_timeout_o = res_timeout_q;
  assign fifo_count_o  = count_q;
  assign busy_o        = w_busy;

endmodule
`default_nettype wire
